mem_access_ctrl: RTL and testbench

Load/store access controller between the processor's memory stage and its two data targets: the 1024-word data RAM and the memory-mapped peripheral bus. It accepts one access at a time and decodes the address with an unsigned compare: addresses below RAM_WORDS go to RAM, all others go to the peripheral bus. It sequences the synchronous-RAM read latency and the peripheral req/ack handshake with a timeout, then returns data to the CPU with a one-cycle completion pulse.

---
 rtl/mem_access_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`timescale 1ns/1ps
// mem_access_ctrl
// Load/store access controller between the CPU memory stage and two data
// targets: a 1024-word synchronous data RAM and a memory-mapped peripheral
// bus. One access is handled at a time. Word addresses below RAM_WORDS go to
// RAM; every other address goes to the peripheral bus. RAM accesses take a
// fixed two cycles after acceptance. Peripheral accesses wait for per_ack_i,
// bounded by TIMEOUT cycles. Completion is a registered one-cycle pulse.
//
// Ports
//   clk_i, rst_ni                  clock, async active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i  access request from the CPU (sampled in IDLE)
//   cpu_rdata_o                    load data register
//   cpu_done_o, cpu_err_o          completion pulse, timeout flag
//   busy_o                         high while an access is in flight
//   ram_addr_o/we_o/wdata_o        RAM port
//   ram_rdata_i                    RAM read data, one cycle after address
//   per_req_o/we_o/addr_o/wdata_o  peripheral request, held until ack/timeout
//   per_rdata_i, per_ack_i         peripheral response
//
// state    | meaning
// IDLE     | waiting for cpu_req_i; completion pulse cycle
// RAM_ACC  | RAM address (and write strobe for stores) presented
// RAM_RD   | RAM read data valid; completes at the next edge
// PER_WAIT | peripheral request held; waiting for ack or timeout

module mem_access_ctrl #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_done_o,
  output logic        cpu_err_o,
  output logic        busy_o,
  output logic [9:0]  ram_addr_o,
  output logic        ram_we_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  output logic        per_req_o,
  output logic        per_we_o,
  output logic [31:0] per_addr_o,
  output logic [31:0] per_wdata_o,
  input  logic [31:0] per_rdata_i,
  input  logic        per_ack_i
);

  // Counter only needs to reach TIMEOUT-1, so it can never wrap.
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_ACC  = 2'd1,
    RAM_RD   = 2'd2,
    PER_WAIT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          addr_d  = cpu_addr_i;
          we_d    = cpu_we_i;
          wdata_d = cpu_wdata_i;
          // Full 32-bit unsigned compare: high addresses never alias into RAM.
          if (cpu_addr_i < RAM_WORDS) begin
            state_d = RAM_ACC;
          end else begin
            state_d = PER_WAIT;
            cnt_d   = '0;
          end
        end
      end
      RAM_ACC: begin
        state_d = RAM_RD;
      end
      RAM_RD: begin
        done_d  = 1'b1;
        if (!we_q) rdata_d = ram_rdata_i;
        state_d = IDLE;
      end
      PER_WAIT: begin
        // Ack takes priority over a coincident timeout.
        if (per_ack_i) begin
          done_d  = 1'b1;
          if (!we_q) rdata_d = per_rdata_i;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          if (!we_q) rdata_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from registered state so that an asynchronous
  // reset drops per_req_o and ram_we_o without waiting for an edge.
  assign busy_o      = (state_q != IDLE);
  assign cpu_rdata_o = rdata_q;
  assign cpu_done_o  = done_q;
  assign cpu_err_o   = err_q;

  assign ram_addr_o  = addr_q[9:0];
  assign ram_we_o    = (state_q == RAM_ACC) && we_q;
  assign ram_wdata_o = wdata_q;

  assign per_req_o   = (state_q == PER_WAIT);
  assign per_we_o    = (state_q == PER_WAIT) && we_q;
  assign per_addr_o  = addr_q;
  assign per_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
// Directed testbench for mem_access_ctrl. Inputs change on the falling edge,
// outputs are sampled on the falling edge (half a cycle from the active edge).
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done, cpu_err, busy;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        per_req, per_we;
  logic [31:0] per_addr, per_wdata;
  logic [31:0] per_rdata;
  logic        per_ack;

  int n_chk  = 0;
  int n_fail = 0;
  int we_cnt = 0;
  int we_base;
  logic       early;
  int         dcount;
  logic [8:0] pat;

  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  mem_access_ctrl #(.RAM_WORDS(1024), .TIMEOUT(15)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rdata_o (cpu_rdata),
    .cpu_done_o  (cpu_done),
    .cpu_err_o   (cpu_err),
    .busy_o      (busy),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .per_req_o   (per_req),
    .per_we_o    (per_we),
    .per_addr_o  (per_addr),
    .per_wdata_o (per_wdata),
    .per_rdata_i (per_rdata),
    .per_ack_i   (per_ack)
  );

  // Synchronous RAM model: read data one cycle after the address.
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      we_cnt <= we_cnt + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Returns at the falling edge just after the accepting edge (edge 0).
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    per_rdata = '0; per_ack = 1'b0;
    #12;
    chk("rst_rdata",   cpu_rdata, 32'h0);
    chk("rst_done",    {31'b0, cpu_done}, 32'h0);
    chk("rst_busy",    {31'b0, busy}, 32'h0);
    chk("rst_per_req", {31'b0, per_req}, 32'h0);
    chk("rst_ram_we",  {31'b0, ram_we}, 32'h0);
    chk("rst_per_addr", per_addr, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Store 0xCAFE_0001 to RAM address 5
    we_base = we_cnt;
    issue(1'b1, 32'd5, 32'hCAFE_0001);
    chk("st_ram_we",    {31'b0, ram_we}, 32'h1);
    chk("st_ram_addr",  {22'b0, ram_addr}, 32'd5);
    chk("st_ram_wdata", ram_wdata, 32'hCAFE_0001);
    chk("st_busy",      {31'b0, busy}, 32'h1);
    chk("st_per_req",   {31'b0, per_req}, 32'h0);
    @(negedge clk);
    chk("st_ram_we_off", {31'b0, ram_we}, 32'h0);
    @(negedge clk);
    chk("st_done",   {31'b0, cpu_done}, 32'h1);
    chk("st_busy_lo", {31'b0, busy}, 32'h0);
    chk("st_rdata_kept", cpu_rdata, 32'h0);
    chk("st_we_cycles", we_cnt - we_base, 32'd1);

    // Load address 5
    issue(1'b0, 32'd5, 32'h0);
    @(negedge clk);
    chk("ld_not_done_early", {31'b0, cpu_done}, 32'h0);
    @(negedge clk);
    chk("ld_done",  {31'b0, cpu_done}, 32'h1);
    chk("ld_err",   {31'b0, cpu_err}, 32'h0);
    chk("ld_rdata", cpu_rdata, 32'hCAFE_0001);
    @(negedge clk);
    chk("ld_done_pulse", {31'b0, cpu_done}, 32'h0);

    // Boundary decode
    issue(1'b0, 32'd1023, 32'h0);
    chk("b1023_ram_addr", {22'b0, ram_addr}, 32'd1023);
    chk("b1023_per_req",  {31'b0, per_req}, 32'h0);
    repeat (2) @(negedge clk);
    chk("b1023_done", {31'b0, cpu_done}, 32'h1);

    issue(1'b0, 32'd1024, 32'h0);
    chk("b1024_per_req",  {31'b0, per_req}, 32'h1);
    chk("b1024_per_addr", per_addr, 32'd1024);
    chk("b1024_per_we",   {31'b0, per_we}, 32'h0);
    per_ack = 1'b1; per_rdata = 32'hBEEF_0400;
    @(negedge clk);
    per_ack = 1'b0;
    chk("b1024_done",  {31'b0, cpu_done}, 32'h1);
    chk("b1024_rdata", cpu_rdata, 32'hBEEF_0400);

    issue(1'b0, 32'hFFFF_FFFF, 32'h0);
    chk("bmax_per_req",  {31'b0, per_req}, 32'h1);
    chk("bmax_per_addr", per_addr, 32'hFFFF_FFFF);
    per_ack = 1'b1; per_rdata = 32'hBEEF_FFFF;
    @(negedge clk);
    per_ack = 1'b0;
    chk("bmax_rdata", cpu_rdata, 32'hBEEF_FFFF);

    // Peripheral load, ack on the 3rd PER_WAIT cycle
    issue(1'b0, 32'h0000_8000, 32'h0);
    repeat (2) @(negedge clk);
    chk("p3_wait_done", {31'b0, cpu_done}, 32'h0);
    chk("p3_wait_req",  {31'b0, per_req}, 32'h1);
    per_ack = 1'b1; per_rdata = 32'h1234_5678;
    @(negedge clk);
    per_ack = 1'b0;
    chk("p3_done",    {31'b0, cpu_done}, 32'h1);
    chk("p3_err",     {31'b0, cpu_err}, 32'h0);
    chk("p3_rdata",   cpu_rdata, 32'h1234_5678);
    chk("p3_req_off", {31'b0, per_req}, 32'h0);
    chk("p3_busy",    {31'b0, busy}, 32'h0);

    // Peripheral store leaves cpu_rdata alone
    issue(1'b1, 32'h0000_9000, 32'h5555_AAAA);
    chk("ps_per_we",    {31'b0, per_we}, 32'h1);
    chk("ps_per_wdata", per_wdata, 32'h5555_AAAA);
    per_ack = 1'b1; per_rdata = 32'hDEAD_DEAD;
    @(negedge clk);
    per_ack = 1'b0;
    chk("ps_done",  {31'b0, cpu_done}, 32'h1);
    chk("ps_rdata", cpu_rdata, 32'h1234_5678);

    // Timeout: no ack, completion exactly 15 edges after acceptance
    issue(1'b0, 32'h0000_2000, 32'h0);
    early = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      early = early | cpu_done | ~per_req;
    end
    chk("to_no_early", {31'b0, early}, 32'h0);
    @(negedge clk);
    chk("to_done",    {31'b0, cpu_done}, 32'h1);
    chk("to_err",     {31'b0, cpu_err}, 32'h1);
    chk("to_rdata",   cpu_rdata, 32'h0);
    chk("to_busy",    {31'b0, busy}, 32'h0);
    chk("to_req_off", {31'b0, per_req}, 32'h0);

    // Ack on the final cycle before timeout wins
    issue(1'b0, 32'h0000_3000, 32'h0);
    repeat (14) @(negedge clk);
    per_ack = 1'b1; per_rdata = 32'hA5A5_5A5A;
    @(negedge clk);
    per_ack = 1'b0;
    chk("last_done",  {31'b0, cpu_done}, 32'h1);
    chk("last_err",   {31'b0, cpu_err}, 32'h0);
    chk("last_rdata", cpu_rdata, 32'hA5A5_5A5A);

    // per_ack in IDLE is ignored
    @(negedge clk);
    per_ack = 1'b1; per_rdata = 32'hFFFF_0000;
    dcount = 0;
    repeat (3) begin
      @(negedge clk);
      dcount = dcount + int'(cpu_done) + int'(busy);
    end
    per_ack = 1'b0;
    chk("idle_ack_ignored", dcount, 32'd0);
    chk("idle_ack_rdata",   cpu_rdata, 32'hA5A5_5A5A);

    // Reset during PER_WAIT
    issue(1'b0, 32'h0000_4000, 32'h0);
    @(negedge clk);
    chk("rw_req_before", {31'b0, per_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_req_async", {31'b0, per_req}, 32'h0);
    chk("rw_busy",      {31'b0, busy}, 32'h0);
    chk("rw_rdata",     cpu_rdata, 32'h0);
    chk("rw_done",      {31'b0, cpu_done}, 32'h0);
    chk("rw_per_addr",  per_addr, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    dcount = 0;
    repeat (3) begin
      @(negedge clk);
      dcount = dcount + int'(cpu_done);
    end
    chk("rw_no_done", dcount, 32'd0);

    // Back-to-back RAM loads with cpu_req held high
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd5;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      pat[j] = cpu_done;
    end
    cpu_req = 1'b0;
    chk("b2b_pattern", {23'b0, pat}, 32'h0000_0124);
    repeat (3) @(negedge clk);
    chk("b2b_rdata", cpu_rdata, 32'hCAFE_0001);
    chk("b2b_idle",  {31'b0, busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
